// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Brief   : Shared constants and types for the N-master memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Arbitration modes selected through the ARB_MODE parameter
  localparam int ARB_FIXED  = 0;
  localparam int ARB_RR     = 1;

  // Master ids are sized for the largest supported master count (8),
  // so one id type serves every legal N_MASTER (minimum 1 bit).
  localparam int MAX_MASTER = 8;
  localparam int ID_W       = (MAX_MASTER > 1) ? $clog2(MAX_MASTER) : 1;

  typedef logic [ID_W-1:0] id_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_id_fifo.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_id_fifo
// Brief   : Synchronous FIFO of master ids; remembers the issuer of every
//           in-flight read so responses return in order.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arb_id_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   push_i,
  input  id_t                    push_id_i,
  input  logic                   pop_i,
  output id_t                    head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  id_t              mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage array; contents are only meaningful between push and pop
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_id_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : N-master to 1-slave arbiter for the req/ready/rvalid memory
//           protocol, with stall lock, fixed or round-robin priority and
//           in-order read response routing.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_MASTER    = 2,
  parameter int ARB_MODE    = 1,
  parameter int OUTSTANDING = 4,
  parameter int XLEN        = 32
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic [N_MASTER-1:0]          m_req,
  input  logic [N_MASTER-1:0]          m_write,
  input  logic [N_MASTER*XLEN/8-1:0]   m_wstrb,
  input  logic [N_MASTER*XLEN-1:0]     m_addr,
  input  logic [N_MASTER*XLEN-1:0]     m_wdata,
  output logic [N_MASTER-1:0]          m_ready,
  output logic [N_MASTER-1:0]          m_rvalid,
  output logic [XLEN-1:0]              m_rdata,
  output logic                         s_req,
  output logic                         s_write,
  output logic [XLEN/8-1:0]            s_wstrb,
  output logic [XLEN-1:0]              s_addr,
  output logic [XLEN-1:0]              s_wdata,
  input  logic                         s_ready,
  input  logic                         s_rvalid,
  input  logic [XLEN-1:0]              s_rdata,
  output logic [$clog2(OUTSTANDING):0] outstanding,
  output logic                         err_unexp_rsp
);

  localparam int SW = XLEN / 8;

  logic                fifo_full;
  logic                fifo_empty;
  id_t                 fifo_head;
  logic [N_MASTER-1:0] elig;
  id_t                 gnt;
  logic                gnt_vld;
  logic                accept;
  logic                push;
  logic                pop;

  logic lock_q,    lock_d;
  id_t  lock_id_q, lock_id_d;
  id_t  rr_ptr_q,  rr_ptr_d;
  logic err_q,     err_d;

  // A read is only eligible with FIFO room; a same-cycle pop does not count,
  // keeping s_rvalid out of the request path.
  assign elig = m_req & (m_write | {N_MASTER{~fifo_full}});

  // Grant: hold the locked master, else first eligible from the start point
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    if (lock_q) begin
      gnt = lock_id_q;
      for (int i = 0; i < N_MASTER; i++) begin
        if (lock_id_q == id_t'(i)) begin
          gnt_vld = elig[i];
        end
      end
    end else begin
      // First pass: indices at or above rr_ptr (all indices in fixed mode)
      for (int i = 0; i < N_MASTER; i++) begin
        if (!gnt_vld && elig[i] &&
            ((ARB_MODE == ARB_FIXED) || (id_t'(i) >= rr_ptr_q))) begin
          gnt_vld = 1'b1;
          gnt     = id_t'(i);
        end
      end
      // Second pass: wrap around to the indices below rr_ptr
      for (int i = 0; i < N_MASTER; i++) begin
        if (!gnt_vld && elig[i]) begin
          gnt_vld = 1'b1;
          gnt     = id_t'(i);
        end
      end
    end
  end

  // Slave payload follows the granted master
  always_comb begin
    s_write = 1'b0;
    s_wstrb = '0;
    s_addr  = '0;
    s_wdata = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      if (gnt == id_t'(i)) begin
        s_write = m_write[i];
        s_wstrb = m_wstrb[i*SW +: SW];
        s_addr  = m_addr[i*XLEN +: XLEN];
        s_wdata = m_wdata[i*XLEN +: XLEN];
      end
    end
  end

  assign s_req   = gnt_vld;
  assign accept  = s_req & s_ready;
  assign push    = accept & ~s_write;
  assign pop     = s_rvalid & ~fifo_empty;
  assign m_rdata = s_rdata;

  generate
    for (genvar i = 0; i < N_MASTER; i++) begin : g_port
      assign m_ready[i]  = accept & (gnt == id_t'(i));
      assign m_rvalid[i] = pop & (fifo_head == id_t'(i));
    end
  endgenerate

  // Next-state for lock, round-robin pointer and sticky error
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    err_d     = err_q;
    if (s_req && !s_ready) begin
      lock_d    = 1'b1;
      lock_id_d = gnt;
    end else if (accept) begin
      lock_d    = 1'b0;
    end
    if (accept && (ARB_MODE == ARB_RR)) begin
      rr_ptr_d = (gnt == id_t'(N_MASTER - 1)) ? '0 : gnt + id_t'(1);
    end
    if (s_rvalid && fifo_empty) begin
      err_d = 1'b1;
    end
  end

  // Arbiter state registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
      err_q     <= err_d;
    end
  end

  assign err_unexp_rsp = err_q;

  mem_arb_id_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_id_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .push_i    (push),
    .push_id_i (gnt),
    .pop_i     (pop),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (outstanding)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Self-checking bench for mem_arbiter (round-robin depth-2 instance
//           plus a fixed-priority instance sharing the same stimulus).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int N    = 3;
  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              rst_b;
  logic [N-1:0]      m_req;
  logic [N-1:0]      m_write;
  logic [N*4-1:0]    m_wstrb;
  logic [N*XLEN-1:0] m_addr;
  logic [N*XLEN-1:0] m_wdata;
  logic              s_ready;
  logic              s_rvalid;
  logic [XLEN-1:0]   s_rdata;

  logic [N-1:0]      m_ready,  m_ready_f;
  logic [N-1:0]      m_rvalid, m_rvalid_f;
  logic [XLEN-1:0]   m_rdata,  m_rdata_f;
  logic              s_req,    s_req_f;
  logic              s_write,  s_write_f;
  logic [3:0]        s_wstrb,  s_wstrb_f;
  logic [XLEN-1:0]   s_addr,   s_addr_f;
  logic [XLEN-1:0]   s_wdata,  s_wdata_f;
  logic [1:0]        outstanding;
  logic [2:0]        outstanding_f;
  logic              err,      err_f;

  int errors = 0;
  int checks = 0;

  int          issued_q[$];
  logic [2:0]  exp_mask_q[$];
  logic [31:0] exp_data_q[$];

  always #5 clk = ~clk;

  mem_arbiter #(.N_MASTER(N), .ARB_MODE(1), .OUTSTANDING(2), .XLEN(XLEN)) dut (
    .clk(clk), .rst_b(rst_b), .m_req(m_req), .m_write(m_write), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_ready(m_ready), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .s_req(s_req), .s_write(s_write), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_ready(s_ready), .s_rvalid(s_rvalid),
    .s_rdata(s_rdata), .outstanding(outstanding), .err_unexp_rsp(err)
  );

  mem_arbiter #(.N_MASTER(N), .ARB_MODE(0), .OUTSTANDING(4), .XLEN(XLEN)) dut_fixed (
    .clk(clk), .rst_b(rst_b), .m_req(m_req), .m_write(m_write), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_ready(m_ready_f), .m_rvalid(m_rvalid_f),
    .m_rdata(m_rdata_f), .s_req(s_req_f), .s_write(s_write_f), .s_wstrb(s_wstrb_f),
    .s_addr(s_addr_f), .s_wdata(s_wdata_f), .s_ready(s_ready), .s_rvalid(s_rvalid),
    .s_rdata(s_rdata), .outstanding(outstanding_f), .err_unexp_rsp(err_f)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    m_req    = '0;
    m_write  = '0;
    m_wstrb  = '1;
    m_addr   = '0;
    m_wdata  = '0;
    s_ready  = 1'b0;
    s_rvalid = 1'b0;
    s_rdata  = '0;
  endtask

  task automatic apply_reset;
    rst_b = 1'b0;
    clear_inputs();
    issued_q.delete();
    tick();
    tick();
    rst_b = 1'b1;
  endtask

  task automatic set_addr(input int m, input logic [31:0] a);
    m_addr[m*XLEN +: XLEN] = a;
  endtask

  // Drives one slave response and records which master must receive it
  task automatic drive_rsp(input logic [31:0] data);
    logic [2:0] mask;
    int id;
    mask = 3'b000;
    if (issued_q.size() > 0) begin
      id   = issued_q.pop_front();
      mask = 3'b001 << id;
    end
    s_rvalid = 1'b1;
    s_rdata  = data;
    exp_mask_q.push_back(mask);
    exp_data_q.push_back(data);
  endtask

  task automatic test_reset;
    rst_b = 1'b0;
    clear_inputs();
    @(negedge clk);
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL reset_s_req: got %b want 0", s_req); end
    checks++; if (m_ready !== 3'b000) begin errors++; $display("FAIL reset_m_ready: got %b want 000", m_ready); end
    checks++; if (m_rvalid !== 3'b000) begin errors++; $display("FAIL reset_m_rvalid: got %b want 000", m_rvalid); end
    checks++; if (outstanding !== 2'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    tick();
    rst_b = 1'b1;
    tick();
  endtask

  task automatic test_single_read;
    logic [2:0]  em;
    logic [31:0] ed;
    s_ready = 1'b1;
    m_req   = 3'b001;
    m_write = 3'b000;
    set_addr(0, 32'h100);
    @(negedge clk);
    checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL single_s_req: got %b want 1", s_req); end
    checks++; if (s_addr !== 32'h100) begin errors++; $display("FAIL single_s_addr: got %h want 00000100", s_addr); end
    checks++; if (m_ready !== 3'b001) begin errors++; $display("FAIL single_m_ready: got %b want 001", m_ready); end
    issued_q.push_back(0);
    tick();
    m_req = 3'b000;
    @(negedge clk);
    checks++; if (outstanding !== 2'd1) begin errors++; $display("FAIL single_outstanding_1: got %0d want 1", outstanding); end
    tick();
    tick();
    drive_rsp(32'hDEADBEEF);
    @(negedge clk);
    em = exp_mask_q.pop_front();
    ed = exp_data_q.pop_front();
    checks++; if (m_rvalid !== em) begin errors++; $display("FAIL single_m_rvalid: got %b want %b", m_rvalid, em); end
    checks++; if (m_rdata !== ed) begin errors++; $display("FAIL single_m_rdata: got %h want %h", m_rdata, ed); end
    tick();
    s_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (outstanding !== 2'd0) begin errors++; $display("FAIL single_outstanding_0: got %0d want 0", outstanding); end
    checks++; if (m_rvalid !== 3'b000) begin errors++; $display("FAIL single_rvalid_low: got %b want 000", m_rvalid); end
    tick();
  endtask

  task automatic test_rr_and_fixed;
    logic [2:0]  exp_rdy [4];
    logic [31:0] exp_wd  [4];
    apply_reset();
    exp_rdy = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_wd  = '{32'hA0, 32'hA1, 32'hA2, 32'hA0};
    s_ready = 1'b1;
    m_write = 3'b111;
    m_req   = 3'b111;
    m_wdata = {32'hA2, 32'hA1, 32'hA0};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (m_ready !== exp_rdy[k]) begin errors++; $display("FAIL rr_grant_%0d: got %b want %b", k, m_ready, exp_rdy[k]); end
      checks++; if (s_wdata !== exp_wd[k]) begin errors++; $display("FAIL rr_wdata_%0d: got %h want %h", k, s_wdata, exp_wd[k]); end
      checks++; if (m_ready_f !== 3'b001) begin errors++; $display("FAIL fixed_grant_%0d: got %b want 001", k, m_ready_f); end
      tick();
    end
    m_req = 3'b110;
    @(negedge clk);
    checks++; if (m_ready_f !== 3'b010) begin errors++; $display("FAIL fixed_after_drop: got %b want 010", m_ready_f); end
    tick();
    clear_inputs();
  endtask

  task automatic test_lock;
    logic [2:0]  em;
    logic [31:0] ed;
    apply_reset();
    s_ready = 1'b0;
    m_write = 3'b000;
    set_addr(0, 32'h300);
    set_addr(1, 32'h310);
    m_req = 3'b010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (s_addr !== 32'h310) begin errors++; $display("FAIL lock_addr_%0d: got %h want 00000310", k, s_addr); end
      checks++; if (m_ready !== 3'b000) begin errors++; $display("FAIL lock_stall_%0d: got %b want 000", k, m_ready); end
      tick();
      m_req = 3'b011;
    end
    s_ready = 1'b1;
    @(negedge clk);
    checks++; if (m_ready !== 3'b010) begin errors++; $display("FAIL lock_accept: got %b want 010", m_ready); end
    issued_q.push_back(1);
    tick();
    m_req = 3'b001;
    @(negedge clk);
    checks++; if (m_ready !== 3'b001) begin errors++; $display("FAIL lock_then_m0: got %b want 001", m_ready); end
    checks++; if (s_addr !== 32'h300) begin errors++; $display("FAIL lock_then_m0_addr: got %h want 00000300", s_addr); end
    issued_q.push_back(0);
    tick();
    m_req = 3'b000;
    for (int k = 0; k < 2; k++) begin
      drive_rsp(32'h1111_0000 + k);
      @(negedge clk);
      em = exp_mask_q.pop_front();
      ed = exp_data_q.pop_front();
      checks++; if (m_rvalid !== em || m_rdata !== ed) begin errors++; $display("FAIL lock_rsp_%0d: got %b/%h want %b/%h", k, m_rvalid, m_rdata, em, ed); end
      tick();
    end
    s_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (outstanding !== 2'd0) begin errors++; $display("FAIL lock_drained: got %0d want 0", outstanding); end
    tick();
  endtask

  task automatic test_full;
    logic [2:0]  em;
    logic [31:0] ed;
    apply_reset();
    s_ready = 1'b1;
    m_req   = 3'b001;
    m_write = 3'b000;
    for (int k = 0; k < 2; k++) begin
      set_addr(0, 32'h200 + 32'(4 * k));
      @(negedge clk);
      checks++; if (m_ready !== 3'b001) begin errors++; $display("FAIL full_read_%0d: got %b want 001", k, m_ready); end
      issued_q.push_back(0);
      tick();
    end
    set_addr(0, 32'h208);
    set_addr(1, 32'h400);
    m_req   = 3'b011;
    m_write = 3'b010;
    @(negedge clk);
    checks++; if (m_ready !== 3'b010) begin errors++; $display("FAIL full_write_passes: got %b want 010", m_ready); end
    checks++; if (s_write !== 1'b1 || s_addr !== 32'h400) begin errors++; $display("FAIL full_write_payload: got %b/%h want 1/00000400", s_write, s_addr); end
    checks++; if (outstanding !== 2'd2) begin errors++; $display("FAIL full_outstanding: got %0d want 2", outstanding); end
    tick();
    m_req   = 3'b001;
    m_write = 3'b000;
    @(negedge clk);
    checks++; if (m_ready !== 3'b000 || s_req !== 1'b0) begin errors++; $display("FAIL full_blocked: got %b/%b want 000/0", m_ready, s_req); end
    tick();
    drive_rsp(32'hAAAA_0000);
    @(negedge clk);
    checks++; if (m_ready !== 3'b000) begin errors++; $display("FAIL full_blocked_on_pop: got %b want 000", m_ready); end
    em = exp_mask_q.pop_front();
    ed = exp_data_q.pop_front();
    checks++; if (m_rvalid !== em || m_rdata !== ed) begin errors++; $display("FAIL full_rsp_0: got %b/%h want %b/%h", m_rvalid, m_rdata, em, ed); end
    tick();
    s_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (m_ready !== 3'b001 || s_addr !== 32'h208) begin errors++; $display("FAIL full_third_read: got %b/%h want 001/00000208", m_ready, s_addr); end
    issued_q.push_back(0);
    tick();
    m_req = 3'b000;
    for (int k = 1; k < 3; k++) begin
      drive_rsp(32'hAAAA_0000 + k);
      @(negedge clk);
      em = exp_mask_q.pop_front();
      ed = exp_data_q.pop_front();
      checks++; if (m_rvalid !== em || m_rdata !== ed) begin errors++; $display("FAIL full_rsp_%0d: got %b/%h want %b/%h", k, m_rvalid, m_rdata, em, ed); end
      tick();
    end
    s_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (outstanding !== 2'd0) begin errors++; $display("FAIL full_drained: got %0d want 0", outstanding); end
    tick();
  endtask

  task automatic test_interleave;
    logic [2:0]  em;
    logic [31:0] ed;
    apply_reset();
    s_ready = 1'b1;
    m_write = 3'b000;
    m_req   = 3'b010;
    @(negedge clk);
    checks++; if (m_ready !== 3'b010) begin errors++; $display("FAIL inter_m1_a: got %b want 010", m_ready); end
    issued_q.push_back(1);
    tick();
    m_req = 3'b001;
    @(negedge clk);
    checks++; if (m_ready !== 3'b001) begin errors++; $display("FAIL inter_m0: got %b want 001", m_ready); end
    issued_q.push_back(0);
    tick();
    m_req = 3'b010;
    drive_rsp(32'h0000_1111);
    @(negedge clk);
    em = exp_mask_q.pop_front();
    ed = exp_data_q.pop_front();
    checks++; if (m_rvalid !== em || m_rdata !== ed) begin errors++; $display("FAIL inter_rsp_0: got %b/%h want %b/%h", m_rvalid, m_rdata, em, ed); end
    tick();
    s_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (m_ready !== 3'b010) begin errors++; $display("FAIL inter_m1_b: got %b want 010", m_ready); end
    issued_q.push_back(1);
    tick();
    m_req = 3'b000;
    for (int k = 1; k < 3; k++) begin
      drive_rsp(32'h0000_1111 * (k + 1));
      @(negedge clk);
      em = exp_mask_q.pop_front();
      ed = exp_data_q.pop_front();
      checks++; if (m_rvalid !== em || m_rdata !== ed) begin errors++; $display("FAIL inter_rsp_%0d: got %b/%h want %b/%h", k, m_rvalid, m_rdata, em, ed); end
      tick();
    end
    s_rvalid = 1'b0;
    tick();
  endtask

  task automatic test_unexp_and_reset;
    logic [2:0] em;
    logic [31:0] ed;
    @(negedge clk);
    checks++; if (outstanding !== 2'd0) begin errors++; $display("FAIL unexp_pre_outstanding: got %0d want 0", outstanding); end
    tick();
    drive_rsp(32'h0BAD_0BAD);
    @(negedge clk);
    em = exp_mask_q.pop_front();
    ed = exp_data_q.pop_front();
    checks++; if (m_rvalid !== em) begin errors++; $display("FAIL unexp_no_rvalid: got %b want %b (data %h)", m_rvalid, em, ed); end
    tick();
    s_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL unexp_err_set: got %b want 1", err); end
    tick();
    tick();
    tick();
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL unexp_err_held: got %b want 1", err); end
    tick();
    s_ready = 1'b1;
    m_write = 3'b000;
    m_req   = 3'b100;
    @(negedge clk);
    checks++; if (m_ready !== 3'b100) begin errors++; $display("FAIL midrst_m2_read: got %b want 100", m_ready); end
    tick();
    m_req = 3'b000;
    @(negedge clk);
    checks++; if (outstanding !== 2'd1) begin errors++; $display("FAIL midrst_inflight: got %0d want 1", outstanding); end
    tick();
    rst_b = 1'b0;
    #1;
    checks++; if (outstanding !== 2'd0) begin errors++; $display("FAIL midrst_outstanding: got %0d want 0", outstanding); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err_clear: got %b want 0", err); end
    tick();
    rst_b = 1'b1;
    drive_rsp(32'h1A7E_1A7E);
    @(negedge clk);
    em = exp_mask_q.pop_front();
    ed = exp_data_q.pop_front();
    checks++; if (m_rvalid !== em) begin errors++; $display("FAIL late_rsp_no_rvalid: got %b want %b (data %h)", m_rvalid, em, ed); end
    tick();
    s_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL late_rsp_err: got %b want 1", err); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_rr_and_fixed();
    test_lock();
    test_full();
    test_interleave();
    test_unexp_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
